// File: rtl/cpu_pkg.sv
// Shared front-end definitions: instruction geometry, HALT opcode and fetch FSM states.
`default_nettype none

package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [5:0] OPC_HALT = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {instruction word, PC} pairs; flush beats push.
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A full buffer may still accept a word when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// Front-end fetch controller: imem req/ack fetch, prefetch buffer, ID issue, redirect and HALT.
`default_nettype none

module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               id_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc_out,
  output logic               halted
);

  localparam int ENTRY_W = INSTR_W + PC_W;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_addr_q, req_addr_d;
  logic            pend_q, pend_d;
  logic            drop_q, drop_d;
  logic            run_q;

  logic               push, pop, flush, full, empty;
  logic [ENTRY_W-1:0] head;
  logic [INSTR_W-1:0] head_word;
  logic [PC_W-1:0]    head_pc;
  logic               head_halt, in_fetch, handshake;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({imem_rdata, imem_addr}),
    .pop       (pop),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign head_word   = head[ENTRY_W-1:PC_W];
  assign head_pc     = head[PC_W-1:0];
  assign in_fetch    = (state_q == FETCH);
  assign head_halt   = in_fetch & ~empty & is_halt(head_word);
  assign instr_valid = in_fetch & ~empty & ~head_halt;
  assign pop         = instr_valid & id_ready;
  assign instruction = empty ? '0 : head_word;
  assign pc_out      = empty ? pc_q : head_pc;
  assign halted      = (state_q == HALT);

  // An unacked request keeps its address even after a redirect has moved pc_q on.
  assign imem_req  = in_fetch & ~head_halt & (pend_q | ~full | pop);
  assign imem_addr = pend_q ? req_addr_q : pc_q;
  assign handshake = imem_req & imem_ack;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    flush      = 1'b0;
    pend_d     = imem_req & ~imem_ack;
    req_addr_d = imem_addr;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (head_halt) begin
          state_d = HALT;
          flush   = 1'b1;
          drop_d  = 1'b0;
        end else begin
          if (handshake) drop_d = 1'b0;
          if (redirect) begin
            pc_d  = redirect_pc;
            flush = 1'b1;
            if (imem_req & ~imem_ack) drop_d = 1'b1;
          end else if (handshake & ~drop_q) begin
            push = 1'b1;
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
      end
      HALT: begin
        if (run & ~run_q) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      run_q      <= run;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a latency-programmable imem model.
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc_out;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_lat  = 0;
  int wait_cnt = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] exp_w [4];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W     (16),
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .halted      (halted)
  );

  // Memory acks after the request has been held for ack_lat cycles (0 = same cycle).
  assign imem_ack   = imem_req && (wait_cnt >= ack_lat);
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    id_ready = 1'b0;
    redirect = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;

    // Reset values
    step(1);
    check_eq("rst_req",   imem_req,    1'b0);
    check_eq("rst_addr",  imem_addr,   16'h0);
    check_eq("rst_instr", instruction, 32'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_pc",    pc_out,      16'h0);
    check_eq("rst_halt",  halted,      1'b0);
    step(1);
    rst_n = 1'b1;

    // Straight-line, zero-wait
    exp_w[0] = 32'h0000_FFFF; exp_w[1] = 32'h0200_EEEE;
    exp_w[2] = 32'h0640_0000; exp_w[3] = 32'h0000_0333;
    for (int i = 0; i < 4; i++) mem[i] = exp_w[i];
    step(1);
    run = 1'b1; id_ready = 1'b1;
    step(1);
    check_eq("sl_req0",   imem_req,    1'b1);
    check_eq("sl_addr0",  imem_addr,   16'h0);
    check_eq("sl_valid0", instr_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check_eq("sl_valid", instr_valid, 1'b1);
      check_eq("sl_instr", instruction, exp_w[k]);
      check_eq("sl_pc",    pc_out,      16'(k));
      check_eq("sl_addr",  imem_addr,   16'(k + 1));
    end

    // Asynchronous reset mid-cycle with a request in flight
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("ar_req",   imem_req,    1'b0);
    check_eq("ar_valid", instr_valid, 1'b0);
    check_eq("ar_halt",  halted,      1'b0);
    check_eq("ar_pc",    pc_out,      16'h0);
    check_eq("ar_addr",  imem_addr,   16'h0);
    check_eq("ar_instr", instruction, 32'h0);
    run = 1'b0; id_ready = 1'b0;
    step(1);
    rst_n = 1'b1;

    // Backpressure: id_ready low for 5 edges
    step(1);
    run = 1'b1;
    step(3);
    check_eq("bp_req_full", imem_req,    1'b0);
    check_eq("bp_valid",    instr_valid, 1'b1);
    check_eq("bp_instr",    instruction, exp_w[0]);
    check_eq("bp_pc",       pc_out,      16'h0);
    for (int k = 0; k < 2; k++) begin
      step(1);
      check_eq("bp_hold_req",   imem_req,    1'b0);
      check_eq("bp_hold_instr", instruction, exp_w[0]);
      check_eq("bp_hold_pc",    pc_out,      16'h0);
    end
    id_ready = 1'b1;
    #1;
    check_eq("bp_req_pop",  imem_req,  1'b1);
    check_eq("bp_addr_pop", imem_addr, 16'h2);
    for (int k = 1; k < 4; k++) begin
      step(1);
      check_eq("bp_rel_instr", instruction, exp_w[k]);
      check_eq("bp_rel_pc",    pc_out,      16'(k));
    end
    do_reset();

    // Redirect while the request for address 3 waits on a slow ack
    ack_lat = 2;
    mem[16'h10] = 32'h1234_5678;
    id_ready = 1'b1;
    step(1);
    run = 1'b1;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h3); i++) step(1);
    check_eq("rd_wait3", {imem_req, imem_addr == 16'h3}, 2'b11);
    redirect = 1'b1; redirect_pc = 16'h0010;
    step(1);
    redirect = 1'b0;
    check_eq("rd_hold_req",  imem_req,    1'b1);
    check_eq("rd_hold_addr", imem_addr,   16'h3);
    check_eq("rd_flush",     instr_valid, 1'b0);
    step(1);
    check_eq("rd_hold_addr2", imem_addr, 16'h3);
    step(1);
    check_eq("rd_new_req",  imem_req,    1'b1);
    check_eq("rd_new_addr", imem_addr,   16'h10);
    check_eq("rd_dropped",  instr_valid, 1'b0);
    for (int i = 0; i < 20 && !instr_valid; i++) step(1);
    check_eq("rd_first_valid", instr_valid, 1'b1);
    check_eq("rd_first_pc",    pc_out,      16'h10);
    check_eq("rd_first_instr", instruction, 32'h1234_5678);
    do_reset();
    ack_lat = 0;

    // HALT at address 4 after two ADDs
    mem[0] = 32'h0; mem[1] = 32'h0;
    mem[2] = 32'h2200_0001; mem[3] = 32'h6201_0000;
    mem[4] = 32'hFC00_0000; mem[5] = 32'h0000_DEAD;
    step(1);
    run = 1'b1; id_ready = 1'b1;
    step(4);
    check_eq("h_add1_valid", instr_valid, 1'b1);
    check_eq("h_add1",       instruction, 32'h2200_0001);
    check_eq("h_add1_pc",    pc_out,      16'h2);
    step(1);
    check_eq("h_add2_valid", instr_valid, 1'b1);
    check_eq("h_add2",       instruction, 32'h6201_0000);
    check_eq("h_add2_pc",    pc_out,      16'h3);
    step(1);
    check_eq("h_head_valid", instr_valid, 1'b0);
    check_eq("h_head_req",   imem_req,    1'b0);
    step(1);
    check_eq("h_halted", halted,      1'b1);
    check_eq("h_req",    imem_req,    1'b0);
    check_eq("h_valid",  instr_valid, 1'b0);
    step(1);
    check_eq("h_no_restart", halted, 1'b1);
    run = 1'b0;
    step(1);
    check_eq("h_run_low", halted, 1'b1);
    run = 1'b1;
    step(1);
    check_eq("h_restart_halt", halted,    1'b0);
    check_eq("h_restart_req",  imem_req,  1'b1);
    check_eq("h_restart_addr", imem_addr, 16'h0);
    do_reset();

    // Wrap-around, then simultaneous ack + redirect
    mem[0] = 32'h1111_0000; mem[1] = 32'h1111_0001; mem[5] = 32'h5555_0005;
    mem[16'hFFFE] = 32'hAAAA_FFFE; mem[16'hFFFF] = 32'hAAAA_FFFF;
    step(1);
    run = 1'b1; id_ready = 1'b1;
    step(1);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step(1);
    redirect = 1'b0;
    check_eq("w_disc0_valid", instr_valid, 1'b0);
    check_eq("w_addr_fffe",   imem_addr,   16'hFFFE);
    step(1);
    check_eq("w_pc_fffe",   pc_out,    16'hFFFE);
    check_eq("w_addr_ffff", imem_addr, 16'hFFFF);
    step(1);
    check_eq("w_pc_ffff",    pc_out,      16'hFFFF);
    check_eq("w_instr_ffff", instruction, 32'hAAAA_FFFF);
    check_eq("w_addr_wrap",  imem_addr,   16'h0000);
    step(1);
    check_eq("w_pc_0",    pc_out,      16'h0000);
    check_eq("w_instr_0", instruction, 32'h1111_0000);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step(1);
    redirect = 1'b0;
    check_eq("sa_valid_a", instr_valid, 1'b0);
    check_eq("sa_addr_a",  imem_addr,   16'hFFFF);
    redirect = 1'b1; redirect_pc = 16'h0005;
    step(1);
    redirect = 1'b0;
    check_eq("sa_disc_valid", instr_valid, 1'b0);
    check_eq("sa_addr_5",     imem_addr,   16'h0005);
    step(1);
    check_eq("sa_valid_5", instr_valid, 1'b1);
    check_eq("sa_pc_5",    pc_out,      16'h0005);
    check_eq("sa_instr_5", instruction, 32'h5555_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
